ws2812b_rx: RTL and testbench

Receiver/decoder for the single-wire WS2812B NRZ protocol. It is the counterpart of the team's WS2812B bit transmitter and is used to loop back and check LED-strip output, or to accept pixel streams from an external controller. It measures the high-pulse width of each bit and assembles 24-bit GRB pixels MSB first. It reports each pixel with an index, detects the >50 us reset gap as end-of-frame, and flags malformed pulses.

---
 rtl/ws2812b_rx_if.sv | 20 ++
 rtl/ws2812b_rx.sv | 100 ++++++++++
 tb/tb_ws2812b_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_rx_if.sv
// ws2812b_rx_if: decoded pixel/frame/status bundle produced by the WS2812B receiver
//   pixel_data   24  last decoded GRB pixel, bit 23 = first bit received
//   pixel_valid   1  one-cycle strobe, pixel_data/pixel_index updated
//   pixel_index   8  pixel position within the current frame, saturating
//   frame_done    1  one-cycle strobe at end-of-frame gap
//   frame_pixels  8  complete pixels in the finished frame, saturating
//   bit_err       1  one-cycle strobe on malformed pulse or partial pixel
//   in_frame      1  high while a frame is being received
//   master = receiver side (drives), slave = consumer side
interface ws2812b_rx_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        bit_err;
  logic        in_frame;
  modport master(output pixel_data, pixel_valid, pixel_index, frame_done, frame_pixels, bit_err, in_frame);
  modport slave(input pixel_data, pixel_valid, pixel_index, frame_done, frame_pixels, bit_err, in_frame);
endinterface

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B NRZ line decoder assembling 24-bit GRB pixels and frames
//   Clock_27mhz  in   system clock
//   rst          in   synchronous reset, active-high
//   WS2812B_IO   in   asynchronous serial data line
//   px           master side of ws2812b_rx_if (pixel, frame and error outputs)
module ws2812b_rx #(
  parameter int unsigned MIN_HIGH_CNT   = 3,
  parameter int unsigned BIT_THRESH_CNT = 17,
  parameter int unsigned MAX_HIGH_CNT   = 40,
  parameter int unsigned RESET_CNT      = 1350
) (
  input  logic Clock_27mhz,
  input  logic rst,
  input  logic WS2812B_IO,
  ws2812b_rx_if.master px
);
  localparam int unsigned LW = $clog2(RESET_CNT + 1);
  typedef enum logic [1:0] {SYNC, WAIT_H, HIGH, LOW} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [5:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic [4:0] bit_cnt;
  logic [23:0] shift;
  logic [7:0] pix_cnt;
  logic rise, fall, low_end, bad;
  logic [23:0] nxt_shift;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  // low_cnt already holds the samples seen before this one, so matching one less marks the full gap
  assign low_end = low_cnt == LW'(RESET_CNT - 1);
  // an over-long high is caught on the sample that would make the count reach the maximum
  assign bad = (fall && high_cnt < 6'(MIN_HIGH_CNT)) || (s2 && high_cnt == 6'(MAX_HIGH_CNT - 1));
  assign nxt_shift = {shift[22:0], high_cnt > 6'(BIT_THRESH_CNT)};
  always_ff @(posedge Clock_27mhz) begin
    if (rst) begin
      {s3, s2, s1} <= '0;
      state <= SYNC;
      high_cnt <= '0;
      low_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      pix_cnt <= '0;
      px.pixel_data <= '0;
      px.pixel_valid <= 1'b0;
      px.pixel_index <= '0;
      px.frame_done <= 1'b0;
      px.frame_pixels <= '0;
      px.bit_err <= 1'b0;
      px.in_frame <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, WS2812B_IO};
      px.pixel_valid <= 1'b0;
      px.frame_done <= 1'b0;
      px.bit_err <= 1'b0;
      case (state)
        SYNC: begin
          low_cnt <= s2 ? '0 : (low_cnt == LW'(RESET_CNT)) ? low_cnt : low_cnt + 1'b1;
          if (!s2 && low_end) state <= WAIT_H;
        end
        WAIT_H: if (rise) begin
          state <= HIGH;
          high_cnt <= 6'd1;
          px.in_frame <= 1'b1;
        end
        HIGH: if (bad) begin
          state <= SYNC;
          low_cnt <= '0;
          bit_cnt <= '0;
          pix_cnt <= '0;
          px.in_frame <= 1'b0;
          px.bit_err <= 1'b1;
        end else if (fall) begin
          shift <= nxt_shift;
          state <= LOW;
          low_cnt <= LW'(1);
          if (bit_cnt == 5'd23) begin
            px.pixel_data <= nxt_shift;
            px.pixel_valid <= 1'b1;
            px.pixel_index <= pix_cnt;
            pix_cnt <= (pix_cnt == 8'hFF) ? pix_cnt : pix_cnt + 8'd1;
            bit_cnt <= '0;
          end else bit_cnt <= bit_cnt + 5'd1;
        end else high_cnt <= high_cnt + 6'd1;
        LOW: if (rise) begin
          state <= HIGH;
          high_cnt <= 6'd1;
        end else if (low_end) begin
          state <= WAIT_H;
          px.frame_done <= 1'b1;
          px.frame_pixels <= pix_cnt;
          px.bit_err <= bit_cnt != 5'd0;
          pix_cnt <= '0;
          bit_cnt <= '0;
          px.in_frame <= 1'b0;
        end else low_cnt <= low_cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812b_rx.sv
// tb_ws2812b_rx: scoreboard bench driving pulse trains against a pulse-width reference model
module tb_ws2812b_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ws = 1'b0;
  always #5 clk = ~clk;
  ws2812b_rx_if u_if();
  ws2812b_rx dut (.Clock_27mhz(clk), .rst(rst), .WS2812B_IO(ws), .px(u_if));
  typedef struct {int kind; int data; int aux;} ev_t;
  ev_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int mode = 0;
  int lowrun = 0;
  int nb = 0;
  int acc = 0;
  int pix = 0;
  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  function automatic void push(int k, int d, int a);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.aux = a;
    q.push_back(e);
  endfunction
  function automatic void m_clear();
    nb = 0;
    acc = 0;
    pix = 0;
  endfunction
  function automatic void m_high(int w);
    if (mode == 0) lowrun = 0;
    else if (w < 3 || w >= 40) begin
      push(2, 0, 0);
      mode = 0;
      lowrun = (w < 3) ? -1 : 0;
      m_clear();
    end else begin
      mode = 2;
      lowrun = 0;
      acc = acc * 2 + ((w > 17) ? 1 : 0);
      nb++;
      if (nb == 24) begin
        push(0, acc, (pix > 255) ? 255 : pix);
        pix++;
        nb = 0;
        acc = 0;
      end
    end
  endfunction
  function automatic void m_low(int n);
    if (mode == 0) begin
      lowrun += n;
      if (lowrun >= 1350) mode = 1;
    end else if (mode == 2) begin
      lowrun += n;
      if (lowrun >= 1350) begin
        push(1, (pix > 255) ? 255 : pix, (nb != 0) ? 1 : 0);
        m_clear();
        mode = 1;
      end
    end
  endfunction
  task automatic hi(int w);
    m_high(w);
    ws = 1'b1;
    repeat (w) @(negedge clk);
  endtask
  task automatic lo(int n);
    m_low(n);
    ws = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_word(int val, int n, int w0, int w1, int l0, int l1);
    for (int i = n - 1; i >= 0; i--) begin
      if (((val >> i) & 1) != 0) begin
        hi(w1);
        lo(l1);
      end else begin
        hi(w0);
        lo(l0);
      end
    end
  endtask
  task automatic check_zero(string tag);
    check({tag, "_pixel_data"}, int'(u_if.pixel_data), 0);
    check({tag, "_pixel_valid"}, int'(u_if.pixel_valid), 0);
    check({tag, "_pixel_index"}, int'(u_if.pixel_index), 0);
    check({tag, "_frame_done"}, int'(u_if.frame_done), 0);
    check({tag, "_frame_pixels"}, int'(u_if.frame_pixels), 0);
    check({tag, "_bit_err"}, int'(u_if.bit_err), 0);
    check({tag, "_in_frame"}, int'(u_if.in_frame), 0);
  endtask
  always @(negedge clk) begin : mon
    ev_t e;
    int k, d, a;
    if (u_if.pixel_valid || u_if.frame_done || u_if.bit_err) begin
      k = u_if.frame_done ? 1 : u_if.pixel_valid ? 0 : 2;
      d = (k == 0) ? int'(u_if.pixel_data) : (k == 1) ? int'(u_if.frame_pixels) : 0;
      a = (k == 0) ? int'(u_if.pixel_index) + (u_if.bit_err ? 256 : 0)
        : (k == 1) ? int'(u_if.bit_err) + (u_if.pixel_valid ? 2 : 0) : 0;
      if (q.size() == 0) check("unexpected_event_kind", k, -1);
      else begin
        e = q.pop_front();
        check("event_kind", k, e.kind);
        check("event_data", d, e.data);
        check("event_aux", a, e.aux);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    lo(1400);
    send_word(32'hFF0000, 24, 11, 23, 23, 11);
    check("mid_frame_in_frame", int'(u_if.in_frame), 1);
    send_word(32'h00A5C3, 24, 11, 23, 23, 11);
    send_word(32'h123456, 24, 11, 23, 23, 11);
    lo(1400);
    check("frame_pixels_hold", int'(u_if.frame_pixels), 3);
    check("after_frame_in_frame", int'(u_if.in_frame), 0);
    send_word(32'hA5F00F, 24, 17, 18, 15, 15);
    lo(1400);
    hi(2);
    lo(600);
    send_word(32'h5A5A5A, 24, 11, 23, 15, 15);
    lo(1400);
    send_word(32'h3C3C3C, 24, 11, 23, 15, 15);
    lo(1400);
    send_word(32'h2AB, 10, 11, 23, 15, 15);
    hi(45);
    check("long_high_in_frame", int'(u_if.in_frame), 0);
    lo(1400);
    send_word(32'hC0FFEE, 24, 11, 23, 15, 15);
    send_word(32'h2D, 6, 11, 23, 15, 15);
    lo(1400);
    check("partial_frame_pixels", int'(u_if.frame_pixels), 1);
    send_word(32'h0F1E2D, 24, 11, 23, 15, 15);
    lo(1400);
    send_word(32'hABC, 12, 11, 23, 15, 15);
    lo(1334);
    send_word(32'hDEF, 12, 11, 23, 15, 15);
    lo(1400);
    send_word(32'h123, 12, 11, 23, 15, 15);
    lo(1335);
    lo(100);
    send_word(32'h9A5, 12, 11, 23, 15, 15);
    lo(5);
    check("pre_rst_in_frame", int'(u_if.in_frame), 1);
    check("pre_rst_pixel_data", int'(u_if.pixel_data), 32'hABCDEF);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    lowrun = 0;
    m_clear();
    send_word(32'h777777, 24, 11, 23, 15, 15);
    lo(1400);
    send_word(32'h13579B, 24, 11, 23, 15, 15);
    lo(1400);
    for (int f = 0; f < 12; f++) begin
      int nbits;
      nbits = int'($urandom_range(48, 1));
      for (int i = 0; i < nbits; i++) begin
        int r, w, l;
        r = int'($urandom_range(99, 0));
        w = (r < 3) ? int'($urandom_range(2, 1)) : (r < 5) ? int'($urandom_range(44, 40)) : int'($urandom_range(39, 3));
        r = int'($urandom_range(99, 0));
        l = (r == 0) ? 1349 : (r == 1) ? 1350 : int'($urandom_range(20, 1));
        hi(w);
        lo(l);
      end
      lo(1360);
    end
    repeat (20) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
